// File: rtl/conv_window_loader_if.sv
// Byte-stream handshake plus packed window/filter outputs of the 2x2 convolution loader.
interface conv_window_loader_if #(
    parameter int K = 2,
    parameter int C = 3
);
    localparam int IMG_BYTES = K * (K + 3) * C;
    localparam int FLT_BYTES = K * K * C;

    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [8*IMG_BYTES-1:0] image;
    logic [8*FLT_BYTES-1:0] filter;
    logic                   win_valid;
    logic                   result_strobe;
    logic                   busy;
    logic [15:0]            frame_count;

    modport master (
        output in_data, in_valid,
        input  in_ready, image, filter, win_valid, result_strobe, busy, frame_count
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, image, filter, win_valid, result_strobe, busy, frame_count
    );
endinterface

// File: rtl/conv_window_loader.sv
// Loads header/filter/image bytes into packed buses, holds them for the core latency,
// then pulses result_strobe for one cycle.
module conv_window_loader #(
    parameter int K            = 2,
    parameter int C            = 3,
    parameter int CORE_LATENCY = 2
) (
    input logic                clk_spi,
    input logic                rst_n,
    conv_window_loader_if.slave bus
);
    localparam int IMG_BYTES = K * (K + 3) * C;
    localparam int FLT_BYTES = K * K * C;
    localparam int MAXB      = (IMG_BYTES > FLT_BYTES) ? IMG_BYTES : FLT_BYTES;
    localparam int CW        = $clog2(MAXB);

    typedef enum logic [2:0] {IDLE, FILT, IMG, HOLD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    lat;
    logic          take;

    // Ready depends on state only, so upstream may hold a byte through HOLD/DONE.
    assign bus.in_ready = (state == IDLE) || (state == FILT) || (state == IMG);
    assign bus.busy     = (state != IDLE);
    assign take         = bus.in_ready & bus.in_valid;

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            lat               <= '0;
            bus.image         <= '0;
            bus.filter        <= '0;
            bus.win_valid     <= 1'b0;
            bus.result_strobe <= 1'b0;
            bus.frame_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        cnt   <= '0;
                        state <= bus.in_data[0] ? FILT : IMG;
                    end
                end
                FILT: begin
                    if (take) begin
                        for (int unsigned i = 0; i < FLT_BYTES; i++) begin
                            if (cnt == CW'(i)) bus.filter[8*i +: 8] <= bus.in_data;
                        end
                        if (cnt == CW'(FLT_BYTES - 1)) begin
                            cnt   <= '0;
                            state <= IMG;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                IMG: begin
                    if (take) begin
                        for (int unsigned i = 0; i < IMG_BYTES; i++) begin
                            if (cnt == CW'(i)) bus.image[8*i +: 8] <= bus.in_data;
                        end
                        if (cnt == CW'(IMG_BYTES - 1)) begin
                            cnt           <= '0;
                            lat           <= '0;
                            bus.win_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (lat == 4'(CORE_LATENCY - 1)) begin
                        bus.result_strobe <= 1'b1;
                        bus.frame_count   <= bus.frame_count + 16'd1;
                        state             <= DONE;
                    end else begin
                        lat <= lat + 4'd1;
                    end
                end
                DONE: begin
                    bus.result_strobe <= 1'b0;
                    bus.win_valid     <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_loader.sv
// Directed bench for conv_window_loader: two instances, CORE_LATENCY 2 and 1.
module tb_conv_window_loader;
    logic clk_spi = 1'b0;
    logic rst_n;
    always #5 clk_spi = ~clk_spi;

    conv_window_loader_if #(.K(2), .C(3)) if0 ();
    conv_window_loader_if #(.K(2), .C(3)) if1 ();

    conv_window_loader #(.K(2), .C(3), .CORE_LATENCY(2)) dut0 (
        .clk_spi(clk_spi), .rst_n(rst_n), .bus(if0.slave)
    );
    conv_window_loader #(.K(2), .C(3), .CORE_LATENCY(1)) dut1 (
        .clk_spi(clk_spi), .rst_n(rst_n), .bus(if1.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [95:0]  exp_f;
    logic [239:0] exp_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Present one byte and wait (bounded) for it to be accepted; returns on the following negedge.
    task automatic push(input bit u, input logic [7:0] b);
        int n;
        n = 0;
        if (u) begin if1.in_valid = 1'b1; if1.in_data = b; end
        else   begin if0.in_valid = 1'b1; if0.in_data = b; end
        while (((u ? if1.in_ready : if0.in_ready) !== 1'b1) && n < 200) begin
            @(negedge clk_spi);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL push_timeout got=stuck exp=accepted byte=%h", b);
        end
        @(negedge clk_spi);
    endtask

    task automatic build_reload_expect();
        for (int i = 0; i < 12; i++) exp_f[8*i +: 8] = 8'(i + 1);
        for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = 8'(8'h10 + i);
    endtask

    task automatic send_reload_frame();
        push(0, 8'h01);
        for (int i = 0; i < 12; i++) push(0, 8'(i + 1));
        for (int i = 0; i < 30; i++) push(0, 8'(8'h10 + i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        @(negedge clk_spi); @(negedge clk_spi);
        rst_n = 1'b1;
        @(negedge clk_spi);
        tests++; if (if0.image !== '0) begin fails++; $display("FAIL rst_image got=%h exp=0", if0.image); end
        tests++; if (if0.filter !== '0) begin fails++; $display("FAIL rst_filter got=%h exp=0", if0.filter); end
        tests++; if ({if0.win_valid, if0.result_strobe, if0.busy} !== 3'b000) begin
            fails++; $display("FAIL rst_flags got=%b exp=000", {if0.win_valid, if0.result_strobe, if0.busy}); end
        tests++; if (if0.frame_count !== 16'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", if0.frame_count); end
        tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", if0.in_ready); end
    endtask

    task automatic test_reload_frame();
        build_reload_expect();
        send_reload_frame();
        if0.in_valid = 1'b0;
        tests++; if ({if0.win_valid, if0.result_strobe, if0.in_ready} !== 3'b100) begin
            fails++; $display("FAIL reload_hold0 got=%b exp=100", {if0.win_valid, if0.result_strobe, if0.in_ready}); end
        @(negedge clk_spi);
        tests++; if ({if0.win_valid, if0.result_strobe} !== 2'b10) begin
            fails++; $display("FAIL reload_hold1 got=%b exp=10", {if0.win_valid, if0.result_strobe}); end
        @(negedge clk_spi);
        tests++; if ({if0.win_valid, if0.result_strobe} !== 2'b11) begin
            fails++; $display("FAIL reload_strobe got=%b exp=11", {if0.win_valid, if0.result_strobe}); end
        tests++; if (if0.frame_count !== 16'd1) begin fails++; $display("FAIL reload_count got=%0d exp=1", if0.frame_count); end
        @(negedge clk_spi);
        tests++; if ({if0.win_valid, if0.result_strobe, if0.busy} !== 3'b000) begin
            fails++; $display("FAIL reload_after got=%b exp=000", {if0.win_valid, if0.result_strobe, if0.busy}); end
        tests++; if (if0.filter !== exp_f) begin fails++; $display("FAIL reload_filter got=%h exp=%h", if0.filter, exp_f); end
        tests++; if (if0.image[7:0] !== 8'h10 || if0.image[239:232] !== 8'h2D) begin
            fails++; $display("FAIL reload_img_ends got=%h/%h exp=10/2d", if0.image[7:0], if0.image[239:232]); end
        tests++; if (if0.image !== exp_i) begin fails++; $display("FAIL reload_image got=%h exp=%h", if0.image, exp_i); end
    endtask

    task automatic test_reuse_filter();
        logic [7:0] hdr [2];
        logic [7:0] fill [2];
        hdr[0] = 8'h00; fill[0] = 8'hFF;
        hdr[1] = 8'hFE; fill[1] = 8'h3C;
        for (int f = 0; f < 2; f++) begin
            push(0, hdr[f]);
            for (int i = 0; i < 30; i++) push(0, fill[f]);
            if0.in_valid = 1'b0;
            tests++; if (if0.win_valid !== 1'b1) begin
                fails++; $display("FAIL reuse_win_valid hdr=%h got=%b exp=1", hdr[f], if0.win_valid); end
            @(negedge clk_spi); @(negedge clk_spi); @(negedge clk_spi);
            for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = fill[f];
            tests++; if (if0.filter !== exp_f) begin
                fails++; $display("FAIL reuse_filter hdr=%h got=%h exp=%h", hdr[f], if0.filter, exp_f); end
            tests++; if (if0.image !== exp_i) begin
                fails++; $display("FAIL reuse_image hdr=%h got=%h exp=%h", hdr[f], if0.image, exp_i); end
            tests++; if (if0.frame_count !== 16'(2 + f)) begin
                fails++; $display("FAIL reuse_count hdr=%h got=%0d exp=%0d", hdr[f], if0.frame_count, 2 + f); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] seq [43];
        int ready_bad;
        ready_bad = 0;
        build_reload_expect();
        seq[0] = 8'h01;
        for (int i = 0; i < 12; i++) seq[1 + i] = 8'(i + 1);
        for (int i = 0; i < 30; i++) seq[13 + i] = 8'(8'h10 + i);
        for (int i = 0; i < 43; i++) begin
            if0.in_valid = 1'b1; if0.in_data = seq[i];
            @(negedge clk_spi);
            if (i < 42) begin
                if (if0.in_ready !== 1'b1) ready_bad++;
                if0.in_valid = 1'b0;
                @(negedge clk_spi);
                if (if0.in_ready !== 1'b1) ready_bad++;
            end
        end
        if0.in_valid = 1'b0;
        tests++; if (ready_bad !== 0) begin fails++; $display("FAIL stall_ready got=%0d drops exp=0", ready_bad); end
        tests++; if (if0.win_valid !== 1'b1) begin fails++; $display("FAIL stall_win_valid got=%b exp=1", if0.win_valid); end
        @(negedge clk_spi); @(negedge clk_spi); @(negedge clk_spi);
        tests++; if (if0.filter !== exp_f) begin fails++; $display("FAIL stall_filter got=%h exp=%h", if0.filter, exp_f); end
        tests++; if (if0.image !== exp_i) begin fails++; $display("FAIL stall_image got=%h exp=%h", if0.image, exp_i); end
        tests++; if (if0.frame_count !== 16'd4) begin fails++; $display("FAIL stall_count got=%0d exp=4", if0.frame_count); end
    endtask

    task automatic test_hold_backpressure();
        build_reload_expect();
        send_reload_frame();
        if0.in_data = 8'h00;  // next header, held pending through HOLD/DONE
        for (int k = 0; k < 3; k++) begin
            tests++; if (if0.in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", k, if0.in_ready); end
            tests++; if (if0.image !== exp_i || if0.win_valid !== 1'b1) begin
                fails++; $display("FAIL bp_image_stable cyc=%0d got=%h exp=%h", k, if0.image, exp_i); end
            @(negedge clk_spi);
        end
        tests++; if ({if0.in_ready, if0.busy} !== 2'b10) begin
            fails++; $display("FAIL bp_idle got=%b exp=10", {if0.in_ready, if0.busy}); end
        @(negedge clk_spi);
        tests++; if ({if0.in_ready, if0.busy} !== 2'b11) begin
            fails++; $display("FAIL bp_header_taken got=%b exp=11", {if0.in_ready, if0.busy}); end
        for (int i = 0; i < 30; i++) push(0, 8'(8'hA0 + i));
        if0.in_valid = 1'b0;
        tests++; if (if0.win_valid !== 1'b1) begin fails++; $display("FAIL bp_win_valid got=%b exp=1", if0.win_valid); end
        @(negedge clk_spi); @(negedge clk_spi); @(negedge clk_spi);
        for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = 8'(8'hA0 + i);
        tests++; if (if0.image !== exp_i) begin fails++; $display("FAIL bp_image got=%h exp=%h", if0.image, exp_i); end
        tests++; if (if0.filter !== exp_f) begin fails++; $display("FAIL bp_filter got=%h exp=%h", if0.filter, exp_f); end
        tests++; if (if0.frame_count !== 16'd6) begin fails++; $display("FAIL bp_count got=%0d exp=6", if0.frame_count); end
    endtask

    task automatic test_mid_frame_reset();
        push(0, 8'h01);
        for (int i = 0; i < 12; i++) push(0, 8'(i + 1));
        for (int i = 0; i < 16; i++) push(0, 8'(8'h10 + i));
        rst_n = 1'b0;
        #1;
        tests++; if (if0.image !== '0 || if0.filter !== '0) begin
            fails++; $display("FAIL mrst_buses got=%h/%h exp=0/0", if0.image, if0.filter); end
        tests++; if ({if0.busy, if0.win_valid, if0.result_strobe, if0.in_ready} !== 4'b0001 || if0.frame_count !== 16'd0) begin
            fails++; $display("FAIL mrst_flags got=%b cnt=%0d exp=0001 cnt=0",
                {if0.busy, if0.win_valid, if0.result_strobe, if0.in_ready}, if0.frame_count); end
        if0.in_valid = 1'b0;
        @(negedge clk_spi);
        rst_n = 1'b1;
        @(negedge clk_spi);
        push(0, 8'h00);
        for (int i = 0; i < 30; i++) push(0, 8'h55);
        if0.in_valid = 1'b0;
        @(negedge clk_spi); @(negedge clk_spi); @(negedge clk_spi);
        for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = 8'h55;
        tests++; if (if0.filter !== '0) begin fails++; $display("FAIL mrst_filter got=%h exp=0", if0.filter); end
        tests++; if (if0.image !== exp_i) begin fails++; $display("FAIL mrst_image got=%h exp=%h", if0.image, exp_i); end
        tests++; if (if0.frame_count !== 16'd1) begin fails++; $display("FAIL mrst_count got=%0d exp=1", if0.frame_count); end
    endtask

    task automatic test_latency1_wrap();
        force if1.frame_count = 16'hFFFF;
        #1;
        release if1.frame_count;
        push(1, 8'h00);
        for (int i = 0; i < 30; i++) push(1, 8'(i * 7));
        if1.in_valid = 1'b0;
        tests++; if ({if1.win_valid, if1.result_strobe} !== 2'b10) begin
            fails++; $display("FAIL l1_hold got=%b exp=10", {if1.win_valid, if1.result_strobe}); end
        @(negedge clk_spi);
        tests++; if ({if1.win_valid, if1.result_strobe} !== 2'b11) begin
            fails++; $display("FAIL l1_strobe got=%b exp=11", {if1.win_valid, if1.result_strobe}); end
        tests++; if (if1.frame_count !== 16'd0) begin fails++; $display("FAIL l1_wrap got=%h exp=0000", if1.frame_count); end
        @(negedge clk_spi);
        tests++; if ({if1.win_valid, if1.result_strobe, if1.busy} !== 3'b000) begin
            fails++; $display("FAIL l1_after got=%b exp=000", {if1.win_valid, if1.result_strobe, if1.busy}); end
        for (int i = 0; i < 30; i++) exp_i[8*i +: 8] = 8'(i * 7);
        tests++; if (if1.image !== exp_i) begin fails++; $display("FAIL l1_image got=%h exp=%h", if1.image, exp_i); end
    endtask

    initial begin
        test_reset();
        test_reload_frame();
        test_reuse_filter();
        test_stall();
        test_hold_backpressure();
        test_mid_frame_reset();
        test_latency1_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
